// File: rtl/primality_top.sv
// primality_top: candidate FIFO fed by a Galois LFSR or cand_in, drained by a trial-division tester.
// Latency: prime_valid pulses NUM_BITS+3 cycles after the pq_fifo_rd_en cycle; one candidate per NUM_BITS+3 cycles.
// Backpressure: cand_ready = !pq_fifo_full; external writes while full are dropped, LFSR mode stalls (no advance).
//
// Ports:
//   aclk, aresetn          clock; reset is synchronous and active-HIGH despite its name
//   use_ext                1 = candidates from cand_in/cand_valid, 0 = from the internal LFSR
//   cand_in, cand_valid    external candidate write request
//   cand_ready             FIFO can accept a write
//   o_lfsr_done            one-cycle pulse following every FIFO write (either source)
//   pq_fifo_full/_empty    FIFO occupancy flags
//   pq_fifo_rd_en          tester pops the FIFO this cycle
//   prime_out, prime_valid last passing candidate and its one-cycle update strobe
module primality_top #(
  parameter int unsigned         NUM_BITS   = 128,
  parameter int unsigned         FIFO_DEPTH = 8,
  parameter logic [NUM_BITS-1:0] LFSR_SEED  = NUM_BITS'(1),
  parameter logic [NUM_BITS-1:0] LFSR_TAPS  = NUM_BITS'(8'hE1) << (NUM_BITS - 8)
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                use_ext,
  input  logic [NUM_BITS-1:0] cand_in,
  input  logic                cand_valid,
  output logic                cand_ready,
  output logic                o_lfsr_done,
  output logic                pq_fifo_full,
  output logic                pq_fifo_empty,
  output logic                pq_fifo_rd_en,
  output logic [NUM_BITS-1:0] prime_out,
  output logic                prime_valid
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(NUM_BITS);
  localparam int NP = 15;
  localparam int unsigned PRIMES [NP] = '{3, 5, 7, 11, 13, 17, 19, 23, 29, 31, 37, 41, 43, 47, 53};

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_REDUCE, S_DECIDE} state_e;

  state_e              state_q, state_d;
  logic [NUM_BITS-1:0] lfsr_q, lfsr_d, lfsr_step;
  logic [NUM_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [AW:0]         count_q, count_d;
  logic [NUM_BITS-1:0] rd_dat_q;
  logic                done_q;
  logic [NUM_BITS-1:0] cand_q, cand_d;
  logic [NUM_BITS-1:0] shift_q, shift_d;
  logic [CW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [5:0]          rem_q [NP];
  logic [5:0]          rem_d [NP];
  logic [NUM_BITS-1:0] prime_q, prime_d;
  logic                pvld_q, pvld_d;

  logic                full, empty, wr_en, rd_en, pass;
  logic [NUM_BITS-1:0] wr_dat;
  logic [6:0]          t;

  assign full   = (count_q == (AW+1)'(FIFO_DEPTH));
  assign empty  = (count_q == '0);
  assign wr_en  = !full && (use_ext ? cand_valid : 1'b1);
  // LFSR candidates are forced odd and full width.
  assign wr_dat = use_ext ? cand_in
                          : (lfsr_q | (NUM_BITS'(1) << (NUM_BITS - 1)) | NUM_BITS'(1));

  assign lfsr_step = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);

  always_comb begin
    lfsr_d = lfsr_q;
    // The all-zero state would lock up the Galois register; recover to the seed.
    if (lfsr_q == '0)               lfsr_d = LFSR_SEED;
    else if (wr_en && !use_ext)     lfsr_d = lfsr_step;
  end

  assign count_d = count_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);

  // Candidate passes if it is 2 or odd >= 3 and no listed prime divides it (unless it is that prime).
  always_comb begin
    pass = (cand_q >= NUM_BITS'(2)) && (cand_q[0] || (cand_q == NUM_BITS'(2)));
    for (int i = 0; i < NP; i++) begin
      if ((rem_q[i] == '0) && (cand_q != NUM_BITS'(PRIMES[i]))) pass = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_en     = 1'b0;
    cand_d    = cand_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    rem_d     = rem_q;
    prime_d   = prime_q;
    pvld_d    = 1'b0;
    t         = '0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          rd_en   = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        cand_d    = rd_dat_q;
        shift_d   = rd_dat_q;
        bit_cnt_d = '0;
        for (int i = 0; i < NP; i++) rem_d[i] = '0;
        state_d   = S_REDUCE;
      end
      S_REDUCE: begin
        // Horner-style residue update, one bit per cycle, all moduli in parallel.
        for (int i = 0; i < NP; i++) begin
          t = {rem_q[i], shift_q[NUM_BITS-1]};
          rem_d[i] = (t >= 7'(PRIMES[i])) ? 6'(t - 7'(PRIMES[i])) : t[5:0];
        end
        shift_d   = shift_q << 1;
        bit_cnt_d = bit_cnt_q + CW'(1);
        if (bit_cnt_q == CW'(NUM_BITS - 1)) state_d = S_DECIDE;
      end
      S_DECIDE: begin
        if (pass) begin
          prime_d = cand_q;
          pvld_d  = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO storage needs no reset: occupancy is tracked by count_q.
  always_ff @(posedge aclk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_dat;
  end

  always_ff @(posedge aclk) begin
    if (aresetn) begin
      state_q   <= S_IDLE;
      lfsr_q    <= LFSR_SEED;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_dat_q  <= '0;
      done_q    <= 1'b0;
      cand_q    <= '0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      for (int i = 0; i < NP; i++) rem_q[i] <= '0;
      prime_q   <= '0;
      pvld_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      count_q   <= count_d;
      done_q    <= wr_en;
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        rd_dat_q <= mem_q[rd_ptr_q];
      end
      cand_q    <= cand_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      rem_q     <= rem_d;
      prime_q   <= prime_d;
      pvld_q    <= pvld_d;
    end
  end

  assign cand_ready    = !full;
  assign o_lfsr_done   = done_q;
  assign pq_fifo_full  = full;
  assign pq_fifo_empty = empty;
  assign pq_fifo_rd_en = rd_en;
  assign prime_out     = prime_q;
  assign prime_valid   = pvld_q;

endmodule

// File: tb/tb_primality_top.sv
// tb_primality_top: 8-bit instance of primality_top with a scoreboard of expected primes.
// Stimulus pushes expected results; an independent negedge monitor pops them on prime_valid.
// The reference decides primality with plain modulo arithmetic and steps a behavioural LFSR.
module tb_primality_top;

  localparam int NB = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          use_ext;
  logic [NB-1:0] cand_in;
  logic          cand_valid;
  logic          cand_ready, o_lfsr_done, pq_fifo_full, pq_fifo_empty, pq_fifo_rd_en;
  logic [NB-1:0] prime_out;
  logic          prime_valid;

  always #5 clk = ~clk;

  primality_top #(
    .NUM_BITS  (NB),
    .FIFO_DEPTH(8),
    .LFSR_SEED (8'd1),
    .LFSR_TAPS (8'hB8)
  ) dut (
    .aclk         (clk),
    .aresetn      (rst),
    .use_ext      (use_ext),
    .cand_in      (cand_in),
    .cand_valid   (cand_valid),
    .cand_ready   (cand_ready),
    .o_lfsr_done  (o_lfsr_done),
    .pq_fifo_full (pq_fifo_full),
    .pq_fifo_empty(pq_fifo_empty),
    .pq_fifo_rd_en(pq_fifo_rd_en),
    .prime_out    (prime_out),
    .prime_valid  (prime_valid)
  );

  int checks = 0;
  int errors = 0;
  logic [NB-1:0] exp_q [$];
  int rd_count = 0, done_count = 0, lfsr_pulses = 0;
  logic lfsr_phase = 1'b0;
  logic [NB-1:0] lfsr_m = 8'd1;
  logic pop_pass_seen = 1'b0;
  logic [15:0] rd_hist = '0;

  localparam int PR [16] = '{2, 3, 5, 7, 11, 13, 17, 19, 23, 29, 31, 37, 41, 43, 47, 53};

  // Survives trial division by every prime <= 53.
  function automatic bit passes(int n);
    if (n < 2) return 1'b0;
    foreach (PR[k]) if ((n % PR[k] == 0) && (n != PR[k])) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit is_prime(int n);
    if (n < 2) return 1'b0;
    for (int d = 2; d * d <= n; d++) if (n % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [NB-1:0] lfsr_next(logic [NB-1:0] s);
    if (s == 0) return 8'd1;
    return (s >> 1) ^ (s[0] ? 8'hB8 : 8'h00);
  endfunction

  task automatic check(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    logic [NB-1:0] c, e;
    if (!rst) begin
      if (o_lfsr_done) done_count++;
      if (pq_fifo_rd_en) begin
        rd_count++;
        if (lfsr_phase) begin
          c      = lfsr_m | 8'h81;
          lfsr_m = lfsr_next(lfsr_m);
          if (passes(int'(c))) begin
            exp_q.push_back(c);
            pop_pass_seen = 1'b1;
          end
        end
      end
      if (prime_valid) begin
        check("latency_rd_en_11_before", int'(rd_hist[10]), 1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse actual=%0d required=no_pulse", prime_out);
        end else begin
          e = exp_q.pop_front();
          check("prime_out", int'(prime_out), int'(e));
        end
        if (lfsr_phase) begin
          lfsr_pulses++;
          check("lfsr_odd", int'(prime_out[0]), 1);
          check("lfsr_ge128", int'(prime_out >= 8'd128), 1);
          check("lfsr_truly_prime", int'(is_prime(int'(prime_out))), 1);
        end
      end
      rd_hist = {rd_hist[14:0], pq_fifo_rd_en};
    end
  end

  task automatic inject(logic [NB-1:0] v);
    @(posedge clk); #1;
    cand_in    = v;
    cand_valid = 1'b1;
    if (passes(int'(v))) exp_q.push_back(v);
    @(posedge clk); #1;
    cand_valid = 1'b0;
    check("lfsr_done_after_write", int'(o_lfsr_done), 1);
  endtask

  task automatic wait_cycles(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [NB-1:0] burst_vals [10];
    int r0, d0, n;
    bit found;
    rst = 1'b1; use_ext = 1'b1; cand_valid = 1'b0; cand_in = '0;

    // Reset held three cycles.
    repeat (3) @(posedge clk);
    #1;
    check("reset_prime_valid", int'(prime_valid), 0);
    check("reset_prime_out", int'(prime_out), 0);
    check("reset_empty", int'(pq_fifo_empty), 1);
    check("reset_full", int'(pq_fifo_full), 0);
    check("reset_rd_en", int'(pq_fifo_rd_en), 0);
    check("reset_lfsr_done", int'(o_lfsr_done), 0);
    rst = 1'b0;

    // Single prime.
    inject(8'd251);
    wait_cycles(30);
    check("t2_drained", exp_q.size(), 0);
    check("t2_prime_out", int'(prime_out), 251);

    // Composites and degenerate values: no pulses, prime_out holds.
    inject(8'd221); inject(8'd255); inject(8'd0); inject(8'd1); inject(8'd4);
    wait_cycles(6 * 11 + 10);
    check("t3_prime_out_holds", int'(prime_out), 251);
    check("t3_drained", exp_q.size(), 0);

    // Small primes including 2 and the largest trial divisor.
    inject(8'd2); inject(8'd3); inject(8'd53); inject(8'd199);
    wait_cycles(60);
    check("t4_drained", exp_q.size(), 0);

    // Random bursts, never deep enough to fill the FIFO.
    for (int b = 0; b < 5; b++) begin
      n = $urandom_range(1, 8);
      for (int j = 0; j < n; j++) inject(NB'($urandom_range(0, 255)));
      wait_cycles(n * 11 + 15);
    end
    check("rand_drained", exp_q.size(), 0);

    // Ten back-to-back writes: the tenth meets a full FIFO and is dropped.
    burst_vals = '{8'd11, 8'd12, 8'd13, 8'd97, 8'd100, 8'd101, 8'd103, 8'd105, 8'd107, 8'd109};
    r0 = rd_count;
    d0 = done_count;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (i == 9) begin
        check("t5_full", int'(pq_fifo_full), 1);
        check("t5_cand_ready_low", int'(cand_ready), 0);
      end
      cand_in    = burst_vals[i];
      cand_valid = 1'b1;
      if (i < 9 && passes(int'(burst_vals[i]))) exp_q.push_back(burst_vals[i]);
    end
    @(posedge clk); #1;
    cand_valid = 1'b0;
    wait_cycles(9 * 11 + 30);
    check("t5_tested_count", rd_count - r0, 9);
    check("t5_write_count", done_count - d0, 9);
    check("t5_drained", exp_q.size(), 0);

    // LFSR mode from a clean reset.
    rst = 1'b1;
    wait_cycles(2);
    lfsr_phase = 1'b1;
    lfsr_m     = 8'd1;
    use_ext    = 1'b0;
    rst        = 1'b0;
    wait_cycles(2000);
    check("t6_pulses_seen", int'(lfsr_pulses > 0), 1);

    // Abort a passing candidate mid-reduction.
    pop_pass_seen = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 3000 && !found; k++) begin
      @(posedge clk); #1;
      if (pop_pass_seen) found = 1'b1;
    end
    check("t6_prime_pop_found", int'(found), 1);
    wait_cycles(3);
    rst = 1'b1;
    wait_cycles(2);
    if (exp_q.size() > 0) exp_q.pop_back();
    lfsr_m = 8'd1;
    check("t6_reset_empty", int'(pq_fifo_empty), 1);
    check("t6_reset_prime_valid", int'(prime_valid), 0);
    rst = 1'b0;
    wait_cycles(600);

    // Stop filling and let the FIFO drain.
    use_ext = 1'b1;
    wait_cycles(9 * 11 + 30);
    check("t6_drained", exp_q.size(), 0);
    check("t6_fifo_empty", int'(pq_fifo_empty), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
